// File: rtl/forwardpipe_chain_pkg.sv
// forwardpipe_chain_pkg: shared helpers for the forward register pipeline
package forwardpipe_chain_pkg;

    localparam int DEFAULT_L     = 8;
    localparam int DEFAULT_DEPTH = 2;

    // Occupancy must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/forwardpipe_stage.sv
// forwardpipe_stage: one registered valid/data slot with combinational ready pass-through
module forwardpipe_stage
    import forwardpipe_chain_pkg::*;
#(
    parameter int L = DEFAULT_L
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         u_valid,
    input  logic [L-1:0] u_data,
    input  logic         r_next,
    output logic         v,
    output logic [L-1:0] d,
    output logic         r
);

    // An empty slot always accepts, so bubbles collapse even while downstream stalls.
    assign r = ~v | r_next;

    // Flush drops validity only; reset also clears the data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
            d <= '0;
        end else if (flush) begin
            v <= 1'b0;
        end else if (r) begin
            v <= u_valid;
            if (u_valid) d <= u_data;
        end
    end

endmodule

// File: rtl/forwardpipe_chain.sv
// forwardpipe_chain: DEPTH-stage forward-registered valid/ready pipeline with flush and occupancy
module forwardpipe_chain
    import forwardpipe_chain_pkg::*;
#(
    parameter int L     = DEFAULT_L,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int OCC_W = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    output logic             ready_f,
    input  logic             valid_f,
    input  logic [L-1:0]     data_f,
    input  logic             ready_b,
    output logic             valid_b,
    output logic [L-1:0]     data_b,
    output logic [OCC_W-1:0] occupancy
);

    logic         v [DEPTH];
    logic [L-1:0] d [DEPTH];
    logic [DEPTH:0] r;
    logic in_fire;
    logic out_fire;

    assign r[DEPTH] = ready_b;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic         u_valid;
        logic [L-1:0] u_data;
        if (i == 0) begin : g_head
            assign u_valid = valid_f;
            assign u_data  = data_f;
        end else begin : g_body
            assign u_valid = v[i-1];
            assign u_data  = d[i-1];
        end
        forwardpipe_stage #(.L(L)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .u_valid (u_valid),
            .u_data  (u_data),
            .r_next  (r[i+1]),
            .v       (v[i]),
            .d       (d[i]),
            .r       (r[i])
        );
    end

    // No transfer on either side during a reset or flush cycle.
    assign ready_f  = r[0] & ~rst & ~flush;
    assign valid_b  = v[DEPTH-1] & ~rst & ~flush;
    assign data_b   = d[DEPTH-1];
    assign in_fire  = valid_f & ready_f;
    assign out_fire = valid_b & ready_b;

    // Count of valid stages, tracked from the boundary handshakes.
    always_ff @(posedge clk) begin
        if (rst || flush) occupancy <= '0;
        else occupancy <= occupancy + OCC_W'(in_fire) - OCC_W'(out_fire);
    end

endmodule

// File: tb/tb_forwardpipe_chain.sv
// tb_forwardpipe_chain: randomized and directed checks of forwardpipe_chain against a queue model
module tb_forwardpipe_chain;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       valid_f;
    logic [7:0] data_f;
    logic       ready_b;

    logic       ready_f2, valid_b2;
    logic [7:0] data_b2;
    logic [1:0] occupancy2;
    logic       ready_f3, valid_b3;
    logic [7:0] data_b3;
    logic [1:0] occupancy3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    forwardpipe_chain #(.L(8), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush), .ready_f(ready_f2), .valid_f(valid_f),
        .data_f(data_f), .ready_b(ready_b), .valid_b(valid_b2), .data_b(data_b2),
        .occupancy(occupancy2)
    );

    forwardpipe_chain #(.L(8), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .flush(flush), .ready_f(ready_f3), .valid_f(valid_f),
        .data_f(data_f), .ready_b(ready_b), .valid_b(valid_b3), .data_b(data_b3),
        .occupancy(occupancy3)
    );

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_reset();
        rst = 1'b1; flush = 1'b0; valid_f = 1'b0; ready_b = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; valid_f = 1'b1; data_f = 8'h99; ready_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (ready_f2 !== 1'b0 || ready_f3 !== 1'b0) begin
                errors++; $display("FAIL reset_ready_f got %b/%b exp 0", ready_f2, ready_f3);
            end
            checks++;
            if (valid_b2 !== 1'b0 || valid_b3 !== 1'b0) begin
                errors++; $display("FAIL reset_valid_b got %b/%b exp 0", valid_b2, valid_b3);
            end
            checks++;
            if (occupancy2 !== 2'd0 || occupancy3 !== 2'd0 || data_b2 !== 8'h00 || data_b3 !== 8'h00) begin
                errors++; $display("FAIL reset_state occ %0d/%0d data %h/%h exp 0", occupancy2, occupancy3, data_b2, data_b3);
            end
        end
        rst = 1'b0; valid_f = 1'b0;
        #1;
        checks++;
        if (ready_f2 !== 1'b1 || ready_f3 !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready_f got %b/%b exp 1", ready_f2, ready_f3);
        end
    endtask

    task automatic test_latency();
        int exp_occ;
        int acc;
        int outs;
        ready_b = 1'b1; flush = 1'b0;
        for (int i = 0; i < 19; i++) begin
            valid_f = (i < 16); data_f = 8'(i + 1);
            #1;
            checks++;
            if (ready_f2 !== 1'b1) begin
                errors++; $display("FAIL lat_ready_f i=%0d got %b exp 1", i, ready_f2);
            end
            cyc();
            acc  = (i + 1 < 16) ? i + 1 : 16;
            outs = (i - 1 < 0) ? 0 : ((i - 1 > 16) ? 16 : i - 1);
            exp_occ = acc - outs;
            checks++;
            if (occupancy2 !== 2'(exp_occ)) begin
                errors++; $display("FAIL lat_occupancy i=%0d got %0d exp %0d", i, occupancy2, exp_occ);
            end
            checks++;
            if (i >= 1 && i <= 16) begin
                if (valid_b2 !== 1'b1 || data_b2 !== 8'(i)) begin
                    errors++; $display("FAIL lat_output i=%0d got v=%b d=%h exp v=1 d=%h", i, valid_b2, data_b2, 8'(i));
                end
            end else if (valid_b2 !== 1'b0) begin
                errors++; $display("FAIL lat_idle i=%0d got v=%b exp 0", i, valid_b2);
            end
        end
    endtask

    task automatic test_fill_stall();
        logic [7:0] words [2];
        words[0] = 8'hA5; words[1] = 8'h5A;
        ready_b = 1'b0; flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            valid_f = 1'b1; data_f = words[k];
            #1;
            checks++;
            if (ready_f2 !== 1'b1) begin
                errors++; $display("FAIL fill_ready_f k=%0d got %b exp 1", k, ready_f2);
            end
            cyc();
            checks++;
            if (occupancy2 !== 2'(k + 1)) begin
                errors++; $display("FAIL fill_occupancy k=%0d got %0d exp %0d", k, occupancy2, k + 1);
            end
        end
        valid_f = 1'b1; data_f = 8'hEE;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (ready_f2 !== 1'b0) begin
                errors++; $display("FAIL full_ready_f k=%0d got %b exp 0", k, ready_f2);
            end
            checks++;
            if (valid_b2 !== 1'b1 || data_b2 !== 8'hA5 || occupancy2 !== 2'd2) begin
                errors++; $display("FAIL stall_hold k=%0d got v=%b d=%h occ=%0d exp v=1 d=a5 occ=2", k, valid_b2, data_b2, occupancy2);
            end
            cyc();
        end
        valid_f = 1'b0; ready_b = 1'b1;
        #1;
        checks++;
        if (ready_f2 !== 1'b1) begin
            errors++; $display("FAIL unstall_ready_f got %b exp 1", ready_f2);
        end
        cyc();
        checks++;
        if (valid_b2 !== 1'b1 || data_b2 !== 8'h5A || occupancy2 !== 2'd1) begin
            errors++; $display("FAIL drain_second got v=%b d=%h occ=%0d exp v=1 d=5a occ=1", valid_b2, data_b2, occupancy2);
        end
        cyc();
        checks++;
        if (valid_b2 !== 1'b0 || occupancy2 !== 2'd0) begin
            errors++; $display("FAIL drain_empty got v=%b occ=%0d exp v=0 occ=0", valid_b2, occupancy2);
        end
    endtask

    task automatic test_bubble();
        logic [7:0] seq_d [4];
        logic       seq_v [4];
        logic [7:0] exp_out [3];
        seq_d[0] = 8'h11; seq_d[1] = 8'h00; seq_d[2] = 8'h22; seq_d[3] = 8'h33;
        seq_v[0] = 1'b1;  seq_v[1] = 1'b0;  seq_v[2] = 1'b1;  seq_v[3] = 1'b1;
        exp_out[0] = 8'h11; exp_out[1] = 8'h22; exp_out[2] = 8'h33;
        pulse_reset();
        ready_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            valid_f = seq_v[k]; data_f = seq_d[k];
            #1;
            checks++;
            if (ready_f3 !== 1'b1) begin
                errors++; $display("FAIL bubble_ready_f k=%0d got %b exp 1", k, ready_f3);
            end
            cyc();
        end
        valid_f = 1'b1; data_f = 8'h44;
        #1;
        checks++;
        if (ready_f3 !== 1'b0 || occupancy3 !== 2'd3) begin
            errors++; $display("FAIL bubble_full got ready_f=%b occ=%0d exp ready_f=0 occ=3", ready_f3, occupancy3);
        end
        valid_f = 1'b0; ready_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (valid_b3 !== 1'b1 || data_b3 !== exp_out[k]) begin
                errors++; $display("FAIL bubble_drain k=%0d got v=%b d=%h exp v=1 d=%h", k, valid_b3, data_b3, exp_out[k]);
            end
            cyc();
        end
        checks++;
        if (valid_b3 !== 1'b0 || occupancy3 !== 2'd0) begin
            errors++; $display("FAIL bubble_empty got v=%b occ=%0d exp v=0 occ=0", valid_b3, occupancy3);
        end
    endtask

    task automatic test_flush();
        pulse_reset();
        ready_b = 1'b0;
        valid_f = 1'b1; data_f = 8'h31;
        cyc();
        data_f = 8'h32;
        cyc();
        checks++;
        if (occupancy2 !== 2'd2) begin
            errors++; $display("FAIL flush_prefill got occ=%0d exp 2", occupancy2);
        end
        data_f = 8'h77; flush = 1'b1;
        #1;
        checks++;
        if (ready_f2 !== 1'b0 || valid_b2 !== 1'b0) begin
            errors++; $display("FAIL flush_gating got ready_f=%b valid_b=%b exp 0/0", ready_f2, valid_b2);
        end
        cyc();
        flush = 1'b0; valid_f = 1'b0;
        #1;
        checks++;
        if (occupancy2 !== 2'd0 || valid_b2 !== 1'b0) begin
            errors++; $display("FAIL flush_cleared got occ=%0d v=%b exp 0/0", occupancy2, valid_b2);
        end
        valid_f = 1'b1; data_f = 8'h88; ready_b = 1'b1;
        cyc();
        valid_f = 1'b0;
        cyc();
        checks++;
        if (valid_b2 !== 1'b1 || data_b2 !== 8'h88) begin
            errors++; $display("FAIL flush_next_word got v=%b d=%h exp v=1 d=88", valid_b2, data_b2);
        end
        cyc();
    endtask

    task automatic test_random();
        logic [7:0] q2 [$];
        logic [7:0] q3 [$];
        pulse_reset();
        for (int c = 0; c < 10010; c++) begin
            if (c < 10000) begin
                valid_f = 1'($urandom_range(0, 1)); data_f = 8'($urandom); ready_b = 1'($urandom_range(0, 1));
            end else begin
                valid_f = 1'b0; ready_b = 1'b1;
            end
            #1;
            checks++;
            if (ready_f2 !== (q2.size() < 2 || ready_b) || ready_f3 !== (q3.size() < 3 || ready_b)) begin
                errors++; $display("FAIL rnd_ready_f c=%0d got %b/%b depth %0d/%0d rb=%b", c, ready_f2, ready_f3, q2.size(), q3.size(), ready_b);
            end
            checks++;
            if (int'(occupancy2) != q2.size() || int'(occupancy3) != q3.size()) begin
                errors++; $display("FAIL rnd_occupancy c=%0d got %0d/%0d exp %0d/%0d", c, occupancy2, occupancy3, q2.size(), q3.size());
            end
            if (valid_b2 === 1'b1 && ready_b) begin
                checks++;
                if (q2.size() == 0) begin
                    errors++; $display("FAIL rnd_dup2 c=%0d got d=%h exp no output", c, data_b2);
                end else begin
                    if (data_b2 !== q2[0]) begin
                        errors++; $display("FAIL rnd_order2 c=%0d got %h exp %h", c, data_b2, q2[0]);
                    end
                    void'(q2.pop_front());
                end
            end
            if (valid_b3 === 1'b1 && ready_b) begin
                checks++;
                if (q3.size() == 0) begin
                    errors++; $display("FAIL rnd_dup3 c=%0d got d=%h exp no output", c, data_b3);
                end else begin
                    if (data_b3 !== q3[0]) begin
                        errors++; $display("FAIL rnd_order3 c=%0d got %h exp %h", c, data_b3, q3[0]);
                    end
                    void'(q3.pop_front());
                end
            end
            if (valid_f && ready_f2 === 1'b1) q2.push_back(data_f);
            if (valid_f && ready_f3 === 1'b1) q3.push_back(data_f);
            cyc();
        end
        checks++;
        if (q2.size() != 0 || q3.size() != 0 || valid_b2 !== 1'b0 || valid_b3 !== 1'b0) begin
            errors++; $display("FAIL rnd_loss got left %0d/%0d valid %b/%b exp 0", q2.size(), q3.size(), valid_b2, valid_b3);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill_stall();
        test_bubble();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
